// File: rtl/calc_pkg.sv
// Shared types for the pipelined carry-lookahead adder/subtractor:
// lookahead group width, operation mode and the per-stage pipeline record.
package calc_pkg;

    localparam int unsigned BLOCK = 4;
    // Widest supported operand; stage records are sized for it and the
    // top level only uses the low N bits.
    localparam int unsigned MAXN  = 64;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } addsub_mode_t;

    // One pipeline stage: psum holds the result blocks already produced,
    // pa/pb hold the operand blocks not yet consumed (current block at LSB).
    typedef struct packed {
        logic             valid;
        addsub_mode_t     mode;
        logic             carry;
        logic [MAXN-1:0]  psum;
        logic [MAXN-1:0]  pa;
        logic [MAXN-1:0]  pb;
    } stage_t;

    // Build the record leaving stage k: insert block k of the sum, pass the
    // block carry-out on, and shift the pending operands down one block.
    function automatic stage_t stage_step(input stage_t          src,
                                          input logic [BLOCK-1:0] s,
                                          input logic            c4,
                                          input int unsigned     k);
        stage_t r;
        r                   = src;
        r.psum[BLOCK*k +: BLOCK] = s;
        r.carry             = c4;
        r.pa                = src.pa >> BLOCK;
        r.pb                = src.pb >> BLOCK;
        return r;
    endfunction

endpackage

// File: rtl/cla4_block.sv
// Combinational 4-bit carry-lookahead group: all internal carries are
// computed directly from generate/propagate terms, with no rippling.
module cla4_block (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4,
    output logic       c3
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    // Flat lookahead equations for every carry in the group
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        s  = p ^ {c3, c2, c1, c0};
    end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined adder/subtractor: one 4-bit lookahead group per stage, block
// carries registered between stages, operands skewed through the pipe.
// The last stage register doubles as the output register.
module pipelined_cla_addsub
    import calc_pkg::*;
#(
    parameter int N     = 16,
    parameter int BLOCK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cin,
    input  logic         sub,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] Sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int NB = N / BLOCK;

    stage_t       st  [NB];
    stage_t       src [NB];
    stage_t       nxt [NB];
    stage_t       in_rec;
    logic [NB-1:0] c3v;
    logic         advance;
    logic [N-1:0] sum_d;
    logic         ovf_d;
    logic         zero_d;
    logic         ovf_q;
    logic         zero_q;
    logic         unused_bits;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage-0 input record; subtract folds the +1 into the initial carry
    always_comb begin
        in_rec            = '0;
        in_rec.valid      = in_valid;
        in_rec.mode       = sub ? SUB : ADD;
        in_rec.carry      = sub ? 1'b1 : cin;
        in_rec.pa[N-1:0]  = A;
        in_rec.pb[N-1:0]  = B;
    end

    for (genvar k = 0; k < NB; k++) begin : g_stage
        logic [3:0] b_eff;
        logic [3:0] s;
        logic       c4;
        logic       c3;

        if (k == 0) begin : g_first
            assign src[k] = in_rec;
        end else begin : g_rest
            assign src[k] = st[k-1];
        end

        assign b_eff = (src[k].mode == SUB) ? ~src[k].pb[3:0] : src[k].pb[3:0];

        cla4_block u_cla (
            .a  (src[k].pa[3:0]),
            .b  (b_eff),
            .c0 (src[k].carry),
            .s  (s),
            .c4 (c4),
            .c3 (c3)
        );

        assign nxt[k] = stage_step(src[k], s, c4, k);
        assign c3v[k] = c3;
    end

    // Flags come from the completed result entering the output register
    always_comb begin
        sum_d  = nxt[NB-1].psum[N-1:0];
        ovf_d  = nxt[NB-1].valid && (nxt[NB-1].carry ^ c3v[NB-1]);
        zero_d = nxt[NB-1].valid && (sum_d == '0);
    end

    // Whole pipeline advances together or holds together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NB; i++) begin
                st[i] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int unsigned i = 0; i < NB; i++) begin
                st[i] <= nxt[i];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign Sum       = st[NB-1].psum[N-1:0];
    assign cout      = st[NB-1].carry;
    assign out_valid = st[NB-1].valid;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Operand/psum bits beyond what the output needs are intentionally dropped
    assign unused_bits = ^{c3v, st[NB-1], nxt[NB-1]};

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub (N=16): expected results are
// queued at acceptance and compared when the DUT hands a result out.
module tb_pipelined_cla_addsub;

    localparam int N  = 16;
    localparam int NB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         cin;
    logic         sub;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] Sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         out_valid;
    logic         out_ready;

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           acc;
        bit           chk_lat;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    pipelined_cla_addsub #(.N(N), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .sub       (sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sum       (Sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain (N+1)-bit arithmetic
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic ci, input logic sb_op);
        exp_t       e;
        logic [N-1:0] bv;
        logic [N:0]   full;
        bv     = sb_op ? ~b : b;
        full   = {1'b0, a} + {1'b0, bv} + {{N{1'b0}}, (sb_op ? 1'b1 : ci)};
        e.sum  = full[N-1:0];
        e.cout = full[N];
        e.ovf  = (a[N-1] == bv[N-1]) && (e.sum[N-1] != a[N-1]);
        e.zero = (e.sum == '0);
        e.acc  = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic ci, input logic sb_op, input bit lat);
        exp_t e;
        int   w;
        @(negedge clk);
        #1;
        A = a; B = b; cin = ci; sub = sb_op; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        e         = model(a, b, ci, sb_op);
        e.acc     = cyc;
        e.chk_lat = lat;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic stop_in();
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Output monitor: scoreboard compare, stall-hold and zero qualification
    logic [N+3:0] saved;
    bit           stalled = 0;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            stalled = 0;
        end else begin
            if (!out_valid) check("zero_idle", zero, 0);
            if (stalled) check("hold", {Sum, cout, ovf, zero, out_valid}, saved);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("sum",  Sum,  e.sum);
                    check("cout", cout, e.cout);
                    check("ovf",  ovf,  e.ovf);
                    check("zero", zero, e.zero);
                    if (e.chk_lat) check("latency", cyc - e.acc, NB);
                end
            end
            stalled = out_valid && !out_ready;
            saved   = {Sum, cout, ovf, zero, out_valid};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] ta [8];
        logic [N-1:0] tb_ [8];
        logic         tc [8];
        logic         ts [8];

        rst = 1'b1; A = '0; B = '0; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_zero",      zero,      0);
        check("rst_sum",       Sum,       0);
        check("rst_cout",      cout,      0);
        check("rst_ovf",       ovf,       0);
        rst = 1'b0;
        #1 check("in_ready_after_rst", in_ready, 1);

        // Directed cases with exact latency
        send(16'h1234, 16'h0FED, 1'b0, 1'b0, 1); stop_in(); drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1); stop_in(); drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1); stop_in(); drain();
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1); stop_in(); drain();
        send(16'hA5A5, 16'hA5A5, 1'b0, 1'b1, 1); stop_in(); drain();
        send(16'h0010, 16'h0003, 1'b1, 1'b1, 1); stop_in(); drain();

        // Back-to-back mixed stream with a 3-cycle output stall
        ta[0] = 16'h5555; tb_[0] = 16'h5555; tc[0] = 1'b0; ts[0] = 1'b1;
        ta[1] = 16'hFFFF; tb_[1] = 16'hFFFF; tc[1] = 1'b1; ts[1] = 1'b0;
        ta[2] = 16'h8000; tb_[2] = 16'h8000; tc[2] = 1'b0; ts[2] = 1'b0;
        ta[3] = 16'h0000; tb_[3] = 16'h0001; tc[3] = 1'b0; ts[3] = 1'b1;
        for (int i = 4; i < 8; i++) begin
            ta[i]  = N'($urandom);
            tb_[i] = N'($urandom);
            tc[i]  = 1'($urandom);
            ts[i]  = 1'(i % 2);
        end
        fork
            begin
                for (int i = 0; i < 8; i++) send(ta[i], tb_[i], tc[i], ts[i], 0);
                stop_in();
            end
            begin
                repeat (5) @(negedge clk);
                out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    #1;
                    check("stall_in_ready",  in_ready,  0);
                    check("stall_out_valid", out_valid, 1);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with transactions in flight
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 0);
        send(16'h3333, 16'h0001, 1'b1, 1'b0, 0);
        send(16'h4444, 16'h0004, 1'b0, 1'b1, 0);
        stop_in();
        @(posedge clk);
        #1;
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_zero",      zero,      0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("in_ready_after_mid_rst", in_ready, 1);
        repeat (10) @(negedge clk);

        // Pipeline still usable after the flush
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1); stop_in(); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 SHALL have parameter N, default 16, meaning operand/result width; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL have parameter BLOCK, default 4, meaning lookahead group width; fixed at 4, with NB = N/4 pipeline stages.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port A, input, N, operand A (two's complement or unsigned).
REQ-006 SHALL have port B, input, N, operand B.
REQ-007 SHALL have port cin, input, 1, carry-in for add; ignored when sub=1.
REQ-008 SHALL have port sub, input, 1: 0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-009 SHALL have port in_valid, input, 1, operand strobe.
REQ-010 SHALL have port in_ready, output, 1, operand accepted when in_valid & in_ready.
REQ-011 SHALL have port Sum, output, N, result.
REQ-012 SHALL have port cout, output, 1, carry out of bit N-1 (for sub: 1 = no borrow).
REQ-013 SHALL have port ovf, output, 1, signed overflow = carry into MSB XOR carry out of MSB.
REQ-014 SHALL have port zero, output, 1, asserted when Sum == 0.
REQ-015 SHALL have port out_valid, output, 1, result qualifier.
REQ-016 SHALL have port out_ready, input, 1, result consumed when out_valid & out_ready.

Function
REQ-017 SHALL compute block k (bits 4k+3:4k) in stage k; intra-block carries by full 4-bit lookahead (g = a&b, p = a^b), never ripple.
REQ-018 SHALL register the block carry-out between stages; stage k consumes the carry registered by stage k-1 in the same transaction.
REQ-019 SHALL skew operands: upper blocks of A/B/mode are carried forward in stage registers until their stage is reached; lower Sum blocks are carried forward to the output.
REQ-020 SHALL have latency exactly NB cycles from accepted input to out_valid when out_ready is held 1.
REQ-021 SHALL sustain one accepted transaction per cycle with out_ready=1; up to NB transactions in flight.
REQ-022 SHALL advance the whole pipeline when advance = !out_valid | out_ready; when advance=0 every stage holds; in_ready = advance.
REQ-023 SHALL insert bubbles (valid=0 stages) when in_valid=0; bubbles collapse only at the output (no per-stage compaction required).
REQ-024 SHALL hold Sum/cout/ovf/zero/out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL produce for sub=1 the two's-complement difference mod 2^N; A=B gives Sum=0, zero=1, cout=1, ovf=0.
REQ-026 SHALL wrap modulo 2^N on unsigned overflow, with cout=1 and Sum = low N bits.
REQ-027 SHALL compute ovf and zero from final-stage values only, registered with Sum.
REQ-028 SHALL accept a new input in the same cycle the output is consumed when the pipeline is full.
REQ-029 SHALL make N=4 degenerate to a single registered stage with latency 1.

Reset
REQ-030 SHALL asynchronously clear all stage valid bits, out_valid, Sum, cout, ovf and all stage data on rst=1.
REQ-031 SHALL drive zero=0 during and after reset until the first valid result, since it is qualified by out_valid.
REQ-032 SHALL discard in-flight transactions on rst mid-operation; no partial result appears after rst deasserts.
REQ-033 SHALL assert in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-034 SHALL place BLOCK, a stage-record typedef (valid, mode, carry, partial sum, pending operands) and an addsub_mode_t enum (ADD, SUB) in shared package calc_pkg.
REQ-035 SHALL instantiate one combinational sub-module cla4_block (a[3:0], b[3:0], c0 -> s[3:0], c4, c3) per stage via generate.

Verification (N=16)
REQ-036 SHALL test A=0x1234, B=0x0FED, cin=0, sub=0 -> Sum=0x2221, cout=0, ovf=0, out_valid exactly 4 cycles later.
REQ-037 SHALL test A=0xFFFF, B=0x0001, sub=0 -> Sum=0x0000, cout=1, zero=1, ovf=0 (full carry propagation across all 4 stages).
REQ-038 SHALL test A=0x7FFF, B=0x0001, sub=0 -> Sum=0x8000, ovf=1; then A=0x8000, B=0x0001, sub=1 -> Sum=0x7FFF, ovf=1, cout=1.
REQ-039 SHALL stream 8 back-to-back mixed add/sub transactions with out_ready held 0 for 3 cycles mid-stream -> in_ready drops, outputs hold, all 8 results emerge in order and correct.
REQ-040 SHALL assert rst with 3 transactions in flight -> out_valid=0 immediately, none of those results ever appears, and in_ready=1 after release.
